// File: rtl/glitch_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// glitch_sweep_ctrl
//
// Fault-injection sequencer. Each attempt holds the console in reset, releases
// it, waits cur_delay cycles, fires the glitch MOSFET for cur_len cycles, then
// watches the debug port for a success code. The outcome of every attempt is
// reported as a 40-bit record over a valid/ready handshake. On a miss the
// glitch delay is advanced and the next attempt starts. On a win the campaign
// stops in DONE with found held high.
//
// Optional feature: define GLITCH_SWEEP_LEN_EN to sweep the glitch length as
// well (length steps each time the delay wraps). Undefined: length is fixed
// at LEN_MIN and LEN_MAX is not used for sweeping.
//
// Ports:
//   CLK          in   1   system clock
//   RST_N        in   1   synchronous active-low reset
//   start        in   1   one-cycle pulse, begins a campaign (IDLE/DONE only)
//   abort        in   1   level, returns to IDLE (wins over start)
//   debug_code   in   8   debug port, already synchronised to CLK
//   reset_out_n  out  1   console reset, active low
//   glitch_out   out  1   glitch MOSFET drive, active high
//   rep_valid    out  1   report record valid
//   rep_ready    in   1   report record accepted
//   rep_data     out  40  {delay[15:0], len[15:0], code[7:0]}
//   busy         out  1   campaign in progress (not IDLE, not DONE)
//   found        out  1   success code seen in this campaign
// -----------------------------------------------------------------------------
module glitch_sweep_ctrl #(
    parameter logic [15:0] RESET_HOLD = 16'h200,
    parameter logic [15:0] DELAY_MIN  = 16'h001,
    parameter logic [15:0] DELAY_MAX  = 16'h300,
    parameter logic [15:0] LEN_MIN    = 16'h100,
    parameter logic [15:0] LEN_MAX    = 16'h180,
    parameter logic [23:0] OBSERVE    = 24'hF0000,
    parameter logic [7:0]  WIN_A      = 8'h88,
    parameter logic [7:0]  WIN_B      = 8'h25
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  debug_code,
    output logic        reset_out_n,
    output logic        glitch_out,
    output logic        rep_valid,
    input  logic        rep_ready,
    output logic [39:0] rep_data,
    output logic        busy,
    output logic        found
);

`ifdef GLITCH_SWEEP_LEN_EN
    localparam logic LEN_SWEEP = 1'b1;
`else
    localparam logic LEN_SWEEP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_DELAY, S_PULSE, S_OBSERVE, S_REPORT, S_DONE
    } state_t;

    state_t      r_state;
    logic [23:0] r_cnt;          // shared phase counter, counts 1..N within a phase
    logic [15:0] r_cur_delay;
    logic [15:0] r_cur_len;
    logic        r_reset_n;
    logic        r_glitch;
    logic        r_rep_valid;
    logic [39:0] r_rep_data;
    logic        r_busy;
    logic        r_found;

    logic        w_win;
    logic [15:0] w_next_len;

    assign w_win = (debug_code == WIN_A) || (debug_code == WIN_B);

    // Length to use after a delay wrap; stays at LEN_MIN when length sweep is off.
    assign w_next_len = (LEN_SWEEP && (r_cur_len < LEN_MAX)) ? r_cur_len + 16'd1 : LEN_MIN;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cur_delay <= DELAY_MIN;
            r_cur_len   <= LEN_MIN;
            r_reset_n   <= 1'b1;
            r_glitch    <= 1'b0;
            r_rep_valid <= 1'b0;
            r_rep_data  <= '0;
            r_busy      <= 1'b0;
            r_found     <= 1'b0;
        end else if (abort) begin
            // Sweep position and found are deliberately kept across an abort.
            r_state     <= S_IDLE;
            r_reset_n   <= 1'b1;
            r_glitch    <= 1'b0;
            r_rep_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RESET;
                        r_cur_delay <= DELAY_MIN;
                        r_cur_len   <= LEN_MIN;
                        r_found     <= 1'b0;
                        r_reset_n   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= 24'd1;
                    end
                end
                S_RESET: begin
                    if (r_cnt == {8'd0, RESET_HOLD}) begin
                        r_reset_n <= 1'b1;
                        r_state   <= S_DELAY;
                        r_cnt     <= 24'd1;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_DELAY: begin
                    // The glitch register rises on the last delay cycle's edge so
                    // the pulse starts exactly cur_delay cycles after release.
                    if (r_cnt == {8'd0, r_cur_delay}) begin
                        r_glitch <= 1'b1;
                        r_state  <= S_PULSE;
                        r_cnt    <= 24'd1;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == {8'd0, r_cur_len}) begin
                        r_glitch <= 1'b0;
                        r_state  <= S_OBSERVE;
                        r_cnt    <= 24'd1;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_OBSERVE: begin
                    // A win on the final window cycle still counts as a win.
                    if (w_win) begin
                        r_rep_valid <= 1'b1;
                        r_rep_data  <= {r_cur_delay, r_cur_len, debug_code};
                        r_found     <= 1'b1;
                        r_state     <= S_REPORT;
                    end else if (r_cnt == OBSERVE) begin
                        r_rep_valid <= 1'b1;
                        r_rep_data  <= {r_cur_delay, r_cur_len, debug_code};
                        r_state     <= S_REPORT;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_REPORT: begin
                    // found can only be set here by this attempt's win, since
                    // start clears it at the beginning of the campaign.
                    if (rep_ready) begin
                        r_rep_valid <= 1'b0;
                        if (r_found) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            if (r_cur_delay < DELAY_MAX) begin
                                r_cur_delay <= r_cur_delay + 16'd1;
                            end else begin
                                r_cur_delay <= DELAY_MIN;
                                r_cur_len   <= w_next_len;
                            end
                            r_state   <= S_RESET;
                            r_reset_n <= 1'b0;
                            r_cnt     <= 24'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign reset_out_n = r_reset_n;
    assign glitch_out  = r_glitch;
    assign rep_valid   = r_rep_valid;
    assign rep_data    = r_rep_data;
    assign busy        = r_busy;
    assign found       = r_found;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for glitch_sweep_ctrl with a small parameter set:
// HOLD=4, DELAY 2..3, LEN 3..4, OBSERVE=5. Expected report records are queued
// before each campaign; a monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_glitch_sweep_ctrl;

    localparam logic [15:0] P_HOLD  = 16'd4;
    localparam logic [15:0] P_DMIN  = 16'd2;
    localparam logic [15:0] P_DMAX  = 16'd3;
    localparam logic [15:0] P_LMIN  = 16'd3;
    localparam logic [15:0] P_LMAX  = 16'd4;
    localparam logic [23:0] P_OBS   = 24'd5;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  debug_code = 8'h00;
    logic        rep_ready = 1'b1;
    logic        reset_out_n;
    logic        glitch_out;
    logic        rep_valid;
    logic [39:0] rep_data;
    logic        busy;
    logic        found;

    glitch_sweep_ctrl #(
        .RESET_HOLD(P_HOLD), .DELAY_MIN(P_DMIN), .DELAY_MAX(P_DMAX),
        .LEN_MIN(P_LMIN), .LEN_MAX(P_LMAX), .OBSERVE(P_OBS),
        .WIN_A(8'h88), .WIN_B(8'h25)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
        .debug_code(debug_code), .reset_out_n(reset_out_n),
        .glitch_out(glitch_out), .rep_valid(rep_valid), .rep_ready(rep_ready),
        .rep_data(rep_data), .busy(busy), .found(found)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    logic [39:0] exp_q[$];

    function automatic logic [39:0] rec(input logic [15:0] d, input logic [15:0] l,
                                        input logic [7:0] c);
        return {d, l, c};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a transfer happens at the next edge when both are high.
    always @(negedge CLK) begin
        if (rep_valid === 1'b1 && rep_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rec_unexpected: got %0h want none", rep_data);
            end else begin
                check("rec", rep_data, exp_q.pop_front());
            end
            n_pop++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic do_abort();
        @(posedge CLK); #1 abort = 1'b1;
        @(posedge CLK); #1 abort = 1'b0;
    endtask

    // Measures one attempt: reset-low length, cycles from reset release to
    // glitch rise, and glitch length.
    task automatic measure(output int low, output int d, output int l);
        int k;
        low = 0; d = 0; l = 0; k = 0;
        @(negedge CLK);
        while (reset_out_n !== 1'b0 && k < 200) begin @(negedge CLK); k++; end
        while (reset_out_n === 1'b0 && k < 200) begin low++; @(negedge CLK); k++; end
        while (glitch_out !== 1'b1 && k < 200) begin d++; @(negedge CLK); k++; end
        while (glitch_out === 1'b1 && k < 200) begin l++; @(negedge CLK); k++; end
        if (k >= 200) begin
            total++;
            bad++;
            $display("FAIL measure_timeout: got %0d cycles want <200", k);
        end
    endtask

    task automatic wait_recs(input int tgt);
        int k;
        k = 0;
        while (n_pop < tgt && k < 400) begin @(negedge CLK); k++; end
        check("rec_count", n_pop, tgt);
    endtask

    initial begin
        int low, d, l, k, base, lows;
        logic [39:0] held;

        // ---- reset values ----
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_reset_out_n", reset_out_n, 1);
        check("rst_glitch", glitch_out, 0);
        check("rst_rep_valid", rep_valid, 0);
        check("rst_rep_data", rep_data, 0);
        check("rst_busy", busy, 0);
        check("rst_found", found, 0);

        // ---- basic sweep, all misses ----
        base = n_pop;
        exp_q.push_back(rec(2, 3, 8'h00));
        exp_q.push_back(rec(3, 3, 8'h00));
`ifdef GLITCH_SWEEP_LEN_EN
        exp_q.push_back(rec(2, 4, 8'h00));
        exp_q.push_back(rec(3, 4, 8'h00));
        exp_q.push_back(rec(2, 3, 8'h00));
`else
        exp_q.push_back(rec(2, 3, 8'h00));
`endif
        pulse_start();
        measure(low, d, l);
        check("a1_reset_low", low, 4);
        check("a1_glitch_delay", d, 2);
        check("a1_glitch_len", l, 3);
        check("a1_busy", busy, 1);
        measure(low, d, l);
        check("a2_reset_low", low, 4);
        check("a2_glitch_delay", d, 3);
        check("a2_glitch_len", l, 3);
        measure(low, d, l);
        check("a3_glitch_delay", d, 2);
`ifdef GLITCH_SWEEP_LEN_EN
        check("a3_glitch_len", l, 4);
        wait_recs(base + 5);
`else
        check("a3_glitch_len", l, 3);
        wait_recs(base + 3);
`endif
        do_abort();
        @(negedge CLK);
        check("sweep_abort_busy", busy, 0);

        // ---- abort during PULSE ----
        pulse_start();
        k = 0;
        while (glitch_out !== 1'b1 && k < 100) begin @(negedge CLK); k++; end
        check("pulse_seen", glitch_out, 1);
        do_abort();
        @(negedge CLK);
        check("abort_glitch", glitch_out, 0);
        check("abort_reset_out_n", reset_out_n, 1);
        check("abort_busy", busy, 0);

        // ---- start and abort together ----
        @(posedge CLK); #1 start = 1'b1; abort = 1'b1;
        @(posedge CLK); #1 start = 1'b0; abort = 1'b0;
        @(negedge CLK);
        check("startabort_busy", busy, 0);
        check("startabort_reset_out_n", reset_out_n, 1);

        // ---- back-pressure in REPORT ----
        @(posedge CLK); #1 rep_ready = 1'b0;
        exp_q.push_back(rec(2, 3, 8'h00));
        pulse_start();
        k = 0;
        while (rep_valid !== 1'b1 && k < 100) begin @(negedge CLK); k++; end
        check("stall_valid_seen", rep_valid, 1);
        held = rep_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("stall_valid", rep_valid, 1);
            check("stall_data", rep_data, held);
            check("stall_reset_out_n", reset_out_n, 1);
        end
        @(posedge CLK); #1 rep_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("accept_valid_drop", rep_valid, 0);
        check("accept_next_reset", reset_out_n, 0);
        do_abort();

        // ---- win on observe cycle 2 ----
        exp_q.push_back(rec(2, 3, 8'h25));
        pulse_start();
        repeat (10) @(posedge CLK);
        #1 debug_code = 8'h25;
        @(negedge CLK);
        check("win_not_early", rep_valid, 0);
        @(posedge CLK); #1 debug_code = 8'h00;
        @(negedge CLK);
        check("win_valid", rep_valid, 1);
        check("win_found", found, 1);
        @(negedge CLK);
        check("done_valid", rep_valid, 0);
        check("done_busy", busy, 0);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (reset_out_n === 1'b0) lows++;
        end
        check("done_no_reset", lows, 0);
        check("done_found_held", found, 1);
        pulse_start();
        measure(low, d, l);
        check("restart_found", found, 0);
        check("restart_delay", d, 2);
        do_abort();

        // ---- RST_N during RESET ----
        pulse_start();
        @(negedge CLK);
        check("pre_rst_reset_low", reset_out_n, 0);
        @(posedge CLK); #1 RST_N = 1'b0;
        @(posedge CLK); #1 RST_N = 1'b1;
        @(negedge CLK);
        check("midrst_reset_out_n", reset_out_n, 1);
        check("midrst_glitch", glitch_out, 0);
        check("midrst_rep_valid", rep_valid, 0);
        check("midrst_rep_data", rep_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_found", found, 0);

        repeat (5) @(negedge CLK);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glitch_sweep_ctrl.md
# glitch_sweep_ctrl

Sequencer for the fault-injection rig: drives console reset, times the glitch MOSFET pulse relative to reset release, watches the 8-bit debug port for a success code, and sweeps glitch delay (and optionally pulse length) across attempts. It replaces button-triggered glitch runs with a deterministic scheduler. Each attempt's outcome is reported as a 40-bit record over a valid/ready handshake to the UART queue.

## Interface
- RESET_HOLD, 16'h200: cycles reset_out_n is held low per attempt (≥1)
- DELAY_MIN, 16'h001: first glitch delay (≥1)
- DELAY_MAX, 16'h300: last glitch delay before wrap (≥DELAY_MIN)
- LEN_MIN, 16'h100: first/fixed glitch length (≥1)
- LEN_MAX, 16'h180: last glitch length before wrap (≥LEN_MIN)
- OBSERVE, 24'hF0000: observation window in cycles (≥1)
- WIN_A, 8'h88 / WIN_B, 8'h25: success codes
- CLK  in  1  system clock, sole clock
- RST_N  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a campaign
- abort  in  1  level; stops the campaign
- debug_code  in  8  debug port, already synchronised to CLK
- reset_out_n  out  1  console reset, active low
- glitch_out  out  1  glitch MOSFET drive, active high
- rep_valid  out  1  report record valid
- rep_ready  in  1  queue accepts record
- rep_data  out  40  {delay[15:0], len[15:0], code[7:0]}
- busy  out  1  state ≠ IDLE and ≠ DONE
- found  out  1  success latched

## Operation
- States: IDLE, RESET, DELAY, PULSE, OBSERVE, REPORT, DONE.
- IDLE: start → RESET; cur_delay=DELAY_MIN, cur_len=LEN_MIN, found=0.
- RESET: reset_out_n=0 for RESET_HOLD cycles → DELAY.
- DELAY: reset_out_n=1; count cur_delay cycles → PULSE.
- PULSE: glitch_out=1 for cur_len cycles → OBSERVE.
- OBSERVE: up to OBSERVE cycles. debug_code ∈ {WIN_A, WIN_B} in any cycle → latch code, found=1, REPORT (win). Timeout → latch current debug_code, REPORT (miss). Checking starts on first OBSERVE cycle.
- REPORT: rep_valid=1 and rep_data stable until rep_ready sampled high. Accept on win → DONE. Accept on miss → advance sweep, → RESET.
- Sweep advance: cur_delay<DELAY_MAX → cur_delay+1; else cur_delay=DELAY_MIN and length step (see Configuration). Campaign continues until win or abort.
- DONE: outputs idle, found=1 held; start → same as from IDLE (clears found, restarts at minima).
- abort=1 in any state: next state IDLE, reset_out_n=1, glitch_out=0, rep_valid=0; cur_delay/cur_len keep values; found keeps value. abort and start in the same cycle: abort wins. start while busy: ignored.
- Arithmetic: 16-bit unsigned delay/length/hold counters, 24-bit observe counter; comparisons unsigned, no overflow possible within parameter limits.

## Timing
- Reset (RST_N=0 at a CLK edge): state IDLE, reset_out_n=1, glitch_out=0, rep_valid=0, rep_data=0, busy=0, found=0, cur_delay=DELAY_MIN, cur_len=LEN_MIN. RST_N mid-attempt behaves identically, reset output released next cycle.
- All outputs registered; start sampled at cycle 0 → reset_out_n=0 from cycle 1 through cycle RESET_HOLD.
- Define T0 = first cycle reset_out_n=1. glitch_out=1 exactly for cycles T0+D … T0+D+L−1 (D=cur_delay, L=cur_len); never glitch during reset low.
- Win detected at cycle t → rep_valid=1 at t+1. Timeout: rep_valid=1 the cycle after the last OBSERVE cycle.
- Handshake transfer on cycle with rep_valid & rep_ready; rep_valid drops next cycle; next attempt's reset_out_n=0 the cycle after transfer.
- found rises with rep_valid on a win.

## Configuration
- GLITCH_SWEEP_LEN_EN defined: on delay wrap, cur_len<LEN_MAX → cur_len+1, else cur_len=LEN_MIN (2-D sweep).
- Not defined: cur_len fixed at LEN_MIN; delay wraps alone; LEN_MAX unused.

## Test plan
- Params HOLD=4, DELAY_MIN=2, DELAY_MAX=3, LEN_MIN=3, OBSERVE=5, rep_ready=1, debug_code=0: start → reset_out_n low 4 cycles, glitch_out high T0+2..T0+4, record {2,3,00}, next attempt delay 3, then wraps to 2.
- Same, macro defined, LEN_MAX=4: third record {2,4,00}, fifth {2,3,00}.
- debug_code=8'h25 injected at OBSERVE cycle 2 → record code 25, found=1, DONE, no further reset pulses; start → found=0, delay=DELAY_MIN.
- rep_ready held low 10 cycles in REPORT → rep_valid and rep_data stable 10 cycles, no reset pulse until accept.
- abort asserted during PULSE → next cycle glitch_out=0, reset_out_n=1, busy=0; start+abort same cycle → stays IDLE.
- RST_N low during RESET → reset_out_n=1 next cycle, all outputs at reset values.
